uart_tx: RTL

//  8N1 UART transmitter. Serialises bytes written into a small TX FIFO onto the tx line.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo.sv | 65 ++++++
 rtl/uart_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, line levels and the TX FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

   localparam int   FRAME_BITS = 10;
   localparam int   DATA_BITS  = 8;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a head word visible on dout and an occupancy count.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push is ignored when full and pop when empty; the caller sees
// this through full/empty. Push and pop on the same edge both take effect.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset (flushes pointers/count)
//   push, din       write request and data
//   pop, dout       read request and current head word
//   full, empty     occupancy flags derived from the registered count
//   count           number of entries held, 0..DEPTH
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int                 PTR_W   = $clog2(DEPTH);
   localparam int                 CNT_W   = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes queued in a small FIFO are sent start/8 data LSB-first/stop.
// Latency: byte accepted at edge E into an empty FIFO with the line idle -> start bit after E+1.
// Backpressure: tx_ready drops when the FIFO is full (registered count); bytes offered then are dropped.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset (abandons any frame, tx goes high)
//   baud_tick_max  bit period minus one in clk cycles, sampled at each frame start
//   tx_data        byte to send, taken on an edge with tx_valid && tx_ready
//   tx_valid       tx_data is valid
//   tx_ready       FIFO has room
//   tx             serial line, registered, idle high
//   tx_busy        a frame is on the line
//   fifo_count     bytes waiting in the FIFO
module uart_tx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int TICK_W     = 14
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [TICK_W-1:0]               baud_tick_max,
   input  logic [7:0]                      tx_data,
   input  logic                            tx_valid,
   output logic                            tx_ready,
   output logic                            tx,
   output logic                            tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t         state_q,    state_d;
   logic [TICK_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [TICK_W-1:0] m_q,        m_d;
   logic [2:0]        bit_idx_q,  bit_idx_d;
   logic [7:0]        shift_q,    shift_d;
   logic              tx_q,       tx_d;

   logic              fifo_full;
   logic              fifo_empty;
   logic [7:0]        fifo_dout;
   logic              fifo_push;
   logic              bit_last;
   logic              frame_start;

   // Ready comes straight from the registered count, never from this cycle's pop.
   assign tx_ready  = !fifo_full;
   assign fifo_push = tx_valid && tx_ready;
   assign tx        = tx_q;

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (tx_data),
      .pop   (frame_start),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bit_last = (baud_cnt_q == m_q);

   // A new frame starts from IDLE, or from the last stop-bit clock so that
   // consecutive frames run with no idle gap.
   assign frame_start = !fifo_empty &&
                        ((state_q == IDLE) || ((state_q == STOP) && bit_last));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         m_q        <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= IDLE_LEVEL;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         m_q        <= m_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
      end
   end

   // Next state and datapath
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      m_d        = m_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;

      if (frame_start) begin
         // Divisor is latched here so a mid-frame change only affects the next frame.
         state_d    = START;
         baud_cnt_d = '0;
         bit_idx_d  = '0;
         shift_d    = fifo_dout;
         m_d        = baud_tick_max;
      end else begin
         case (state_q)
            IDLE: begin
            end
            START: begin
               if (bit_last) begin
                  state_d    = DATA;
                  baud_cnt_d = '0;
                  bit_idx_d  = '0;
               end else begin
                  baud_cnt_d = baud_cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (bit_last) begin
                  baud_cnt_d = '0;
                  shift_d    = {1'b0, shift_q[7:1]};
                  if (bit_idx_q == LAST_BIT) begin
                     state_d = STOP;
                  end else begin
                     bit_idx_d = bit_idx_q + 1'b1;
                  end
               end else begin
                  baud_cnt_d = baud_cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (bit_last) begin
                  state_d    = IDLE;
                  baud_cnt_d = '0;
               end else begin
                  baud_cnt_d = baud_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs: the line level is decoded from the next state and registered,
   // so tx only moves on clock edges.
   always_comb begin
      tx_busy = (state_q != IDLE);
      tx_d    = IDLE_LEVEL;
      case (state_d)
         IDLE:    tx_d = IDLE_LEVEL;
         START:   tx_d = START_BIT;
         DATA:    tx_d = shift_d[0];
         STOP:    tx_d = STOP_BIT;
         default: tx_d = IDLE_LEVEL;
      endcase
   end

endmodule
